// File: rtl/sram_like_arbiter.sv
// Two-port SRAM-like request arbiter: data side wins, a stalled request
// holds the grant, and an order FIFO routes returns back to their source.
module sram_like_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic [3:0]  outstanding,
  output logic        proto_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_INST,
    GNT_DATA
  } gnt_t;

  gnt_t           gnt;
  logic           lock;
  logic           lock_owner;
  logic [DEPTH-1:0] fifo;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [3:0]     count;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           head_id;

  assign full    = (count == 4'(DEPTH));
  assign empty   = (count == 4'd0);
  assign head_id = fifo[rd_ptr];

  // Gating with resetn keeps every strobe low while reset is asserted.
  always_comb begin
    gnt = GNT_NONE;
    priority case (1'b1)
      !resetn:  gnt = GNT_NONE;
      lock:     gnt = lock_owner ? GNT_DATA : GNT_INST;
      full:     gnt = GNT_NONE;
      data_req: gnt = GNT_DATA;
      inst_req: gnt = GNT_INST;
      default:  gnt = GNT_NONE;
    endcase
  end

  always_comb begin
    m_req        = 1'b0;
    m_wr         = 1'b0;
    m_size       = 2'd0;
    m_wstrb      = 4'd0;
    m_addr       = 32'd0;
    m_wdata      = 32'd0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    unique case (gnt)
      GNT_INST: begin
        m_req        = inst_req;
        m_wr         = inst_wr;
        m_size       = inst_size;
        m_wstrb      = inst_wstrb;
        m_addr       = inst_addr;
        m_wdata      = inst_wdata;
        inst_addr_ok = m_addr_ok;
      end
      GNT_DATA: begin
        m_req        = data_req;
        m_wr         = data_wr;
        m_size       = data_size;
        m_wstrb      = data_wstrb;
        m_addr       = data_addr;
        m_wdata      = data_wdata;
        data_addr_ok = m_addr_ok;
      end
      default: ;
    endcase
  end

  assign push = m_req & m_addr_ok;
  assign pop  = resetn & m_data_ok & ~empty;

  assign inst_data_ok = pop & ~head_id;
  assign data_data_ok = pop & head_id;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign outstanding  = count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock       <= 1'b0;
      lock_owner <= 1'b0;
    end else if (m_req && !m_addr_ok) begin
      lock       <= 1'b1;
      lock_owner <= (gnt == GNT_DATA);
    end else if (m_req && m_addr_ok) begin
      lock       <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 4'd0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= (gnt == GNT_DATA);
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Empty is judged on the registered count, before any same-cycle push.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      proto_err <= 1'b0;
    end else if (m_data_ok && empty) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: grant priority, lock, ordering,
// full gating, protocol error and asynchronous reset.
module tb_sram_like_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic [3:0]  outstanding;
  logic        proto_err;

  int checks;
  int failures;

  sram_like_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] IA = 32'h1000_0010;
  localparam logic [31:0] DA = 32'h2000_0020;

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
    inst_addr = IA; inst_wdata = 32'h1111_1111;
    data_req = 1; data_wr = 0; data_size = 2'd1; data_wstrb = 4'h3;
    data_addr = DA; data_wdata = 32'h2222_2222;
    m_addr_ok = 1; m_data_ok = 0; m_rdata = 32'h0;

    // Reset state with requests pending
    #12;
    chk("rst_m_req", m_req, 0);
    chk("rst_d_aok", data_addr_ok, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_perr", proto_err, 0);
    data_req = 0;
    m_addr_ok = 0;
    cyc();
    resetn = 1'b1;
    cyc();

    // Data wins over inst
    inst_req = 1; data_req = 1; m_addr_ok = 1; #1;
    chk("pri_m_req", m_req, 1);
    chk("pri_m_addr", m_addr, DA);
    chk("pri_m_size", m_size, 2'd1);
    chk("pri_d_aok", data_addr_ok, 1);
    chk("pri_i_aok", inst_addr_ok, 0);
    cyc();
    chk("pri_out", outstanding, 1);
    inst_req = 0; data_req = 0; m_addr_ok = 0;
    m_data_ok = 1; m_rdata = 32'hcafe_0001; #1;
    chk("pri_d_dok", data_data_ok, 1);
    chk("pri_i_dok", inst_data_ok, 0);
    chk("pri_rdata", data_rdata, 32'hcafe_0001);
    cyc();
    m_data_ok = 0;
    chk("pri_out0", outstanding, 0);

    // Order: inst, data(write), inst then three returns
    inst_req = 1; m_addr_ok = 1;
    cyc();
    inst_req = 0; data_req = 1; data_wr = 1; data_wstrb = 4'h5; #1;
    chk("ord_m_wr", m_wr, 1);
    chk("ord_m_wstrb", m_wstrb, 4'h5);
    chk("ord_m_wdata", m_wdata, 32'h2222_2222);
    cyc();
    data_req = 0; data_wr = 0; inst_req = 1;
    cyc();
    chk("ord_out3", outstanding, 3);
    inst_req = 0; m_addr_ok = 0;
    m_data_ok = 1; m_rdata = 32'h0bad_0001; #1;
    chk("ord1_i", inst_data_ok, 1);
    chk("ord1_d", data_data_ok, 0);
    chk("ord1_rd", inst_rdata, 32'h0bad_0001);
    cyc();
    chk("ord2_d", data_data_ok, 1);
    chk("ord2_i", inst_data_ok, 0);
    cyc();
    chk("ord3_i", inst_data_ok, 1);
    cyc();
    m_data_ok = 0; #1;
    chk("ord_out0", outstanding, 0);

    // Lock: stalled inst is not preempted by data
    inst_req = 1; m_addr_ok = 0;
    cyc(); cyc(); cyc();
    data_req = 1; #1;
    chk("lck_m_addr", m_addr, IA);
    chk("lck_d_aok", data_addr_ok, 0);
    cyc();
    m_addr_ok = 1; #1;
    chk("lck_i_aok", inst_addr_ok, 1);
    chk("lck_d_aok2", data_addr_ok, 0);
    chk("lck_m_addr2", m_addr, IA);
    cyc();
    chk("lck_out1", outstanding, 1);
    inst_req = 0; #1;
    chk("lck_m_addr3", m_addr, DA);
    chk("lck_d_aok3", data_addr_ok, 1);
    cyc();
    data_req = 0; m_addr_ok = 0; m_data_ok = 1; #1;
    chk("lck_ret_i", inst_data_ok, 1);
    cyc();
    chk("lck_ret_d", data_data_ok, 1);
    cyc();
    m_data_ok = 0;
    chk("lck_out0", outstanding, 0);

    // Full gating, then same-cycle push and pop
    data_req = 1; m_addr_ok = 1;
    cyc(); cyc(); cyc(); cyc();
    chk("full_out", outstanding, 4);
    chk("full_m_req", m_req, 0);
    chk("full_d_aok", data_addr_ok, 0);
    m_data_ok = 1; #1;
    chk("full_pop_m_req", m_req, 0);
    chk("full_pop_dok", data_data_ok, 1);
    cyc();
    chk("full_out3", outstanding, 3);
    chk("pp_m_req", m_req, 1);
    chk("pp_dok", data_data_ok, 1);
    cyc();
    chk("pp_out3", outstanding, 3);
    data_req = 0; m_addr_ok = 0;
    cyc(); cyc(); cyc();
    chk("drain_out0", outstanding, 0);
    m_data_ok = 0;

    // Return with nothing outstanding
    cyc();
    m_data_ok = 1; #1;
    chk("perr_i_dok", inst_data_ok, 0);
    chk("perr_d_dok", data_data_ok, 0);
    cyc();
    m_data_ok = 0;
    chk("perr_set", proto_err, 1);
    chk("perr_out", outstanding, 0);
    cyc(); cyc();
    chk("perr_hold", proto_err, 1);

    // Asynchronous reset with two outstanding and a held lock
    data_req = 1; m_addr_ok = 1;
    cyc(); cyc();
    data_req = 0; inst_req = 1; m_addr_ok = 0;
    cyc();
    chk("ar_out2", outstanding, 2);
    data_req = 1; m_addr_ok = 1;
    #2 resetn = 1'b0;
    #1;
    chk("ar_m_req", m_req, 0);
    chk("ar_i_aok", inst_addr_ok, 0);
    chk("ar_d_aok", data_addr_ok, 0);
    chk("ar_out0", outstanding, 0);
    chk("ar_perr", proto_err, 0);
    data_req = 0; inst_req = 0; m_addr_ok = 0;
    cyc();
    resetn = 1'b1;
    cyc();
    inst_req = 1; data_req = 1; #1;
    chk("ar_nolock", m_addr, DA);
    inst_req = 0; data_req = 0;
    m_data_ok = 1; #1;
    chk("ar_dok", data_data_ok, 0);
    cyc();
    m_data_ok = 0;
    chk("ar_perr2", proto_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
